// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NumReq byte streams with
// line-locked round-robin grants, polling TX-full status before every byte write.
module uart_tx_arbiter #(
    parameter int unsigned          NumReq      = 3,
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [AddrWidth-1:0] UartBase    = 32'h8000_1000,
    parameter logic [7:0]           LineEnd     = 8'h0A,
    parameter int unsigned          MaxBurst    = 64,
    parameter int unsigned          LockTimeout = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumReq-1:0]      req_valid_i,
    input  logic [NumReq*8-1:0]    req_data_i,
    output logic [NumReq-1:0]      req_ready_o,
    output logic [NumReq-1:0]      grant_o,
    output logic                   busy_o,
    output logic                   host_req_o,
    output logic [AddrWidth-1:0]   host_addr_o,
    output logic                   host_we_o,
    output logic [3:0]             host_be_o,
    output logic [DataWidth-1:0]   host_wdata_o,
    input  logic                   host_rvalid_i,
    input  logic [DataWidth-1:0]   host_rdata_i
);
    localparam int unsigned IW = $clog2(NumReq);
    localparam int unsigned BW = $clog2(MaxBurst + 1);
    localparam int unsigned TW = $clog2(LockTimeout + 1);

    typedef enum logic [2:0] {IDLE, POLL, WAIT_STAT, WRITE, WAIT_WR} state_t;

    state_t        state, state_d;
    logic          locked, found;
    logic [IW-1:0] owner, ptr, sel, cur, owner_nxt;
    logic [IW:0]   j;
    logic [BW-1:0] burst, burst_inc;
    logic [TW-1:0] tmo;
    logic [7:0]    tx_byte;
    logic          unused_rdata;

    assign unused_rdata = ^{host_rdata_i[DataWidth-1:2], host_rdata_i[0]};

    // Scan downwards so the requester closest to the pointer is assigned last and wins.
    always_comb begin
        found = 1'b0;
        sel = '0;
        j = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            j = {1'b0, ptr} + (IW+1)'(i);
            j = (j >= (IW+1)'(NumReq)) ? j - (IW+1)'(NumReq) : j;
            if (req_valid_i[j[IW-1:0]]) begin
                found = 1'b1;
                sel = j[IW-1:0];
            end
        end
    end

    assign cur       = locked ? owner : sel;
    assign owner_nxt = (owner == IW'(NumReq - 1)) ? '0 : owner + 1'b1;
    assign burst_inc = (burst == BW'(MaxBurst)) ? burst : burst + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = (locked ? req_valid_i[owner] : found) ? POLL : IDLE;
            POLL:      state_d = WAIT_STAT;
            WAIT_STAT: state_d = host_rvalid_i ? (host_rdata_i[1] ? POLL : WRITE) : WAIT_STAT;
            WRITE:     state_d = WAIT_WR;
            WAIT_WR:   state_d = host_rvalid_i ? IDLE : WAIT_WR;
            default:   state_d = IDLE;
        endcase
    end

    // The byte is captured once on leaving IDLE; repolls reuse it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            locked  <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
            burst   <= '0;
            tmo     <= '0;
            tx_byte <= '0;
        end else begin
            if (state == IDLE && state_d == POLL) tx_byte <= req_data_i[{cur, 3'b000} +: 8];
            if (state == IDLE && !locked && found) begin
                locked <= 1'b1;
                owner  <= sel;
                burst  <= '0;
            end
            if (state == IDLE && locked && !req_valid_i[owner]) begin
                tmo <= (tmo == TW'(LockTimeout - 1)) ? '0 : tmo + 1'b1;
                if (tmo == TW'(LockTimeout - 1)) begin
                    locked <= 1'b0;
                    ptr    <= owner_nxt;
                end
            end else begin
                tmo <= '0;
            end
            if (state == WAIT_WR && host_rvalid_i) begin
                burst <= burst_inc;
                if (tx_byte == LineEnd || burst_inc == BW'(MaxBurst)) begin
                    locked <= 1'b0;
                    ptr    <= owner_nxt;
                end
            end
        end
    end

    always_comb begin
        busy_o       = state != IDLE;
        host_req_o   = state == POLL || state == WRITE;
        host_we_o    = state == WRITE;
        host_be_o    = host_req_o ? 4'b0001 : 4'b0000;
        host_addr_o  = (state == POLL) ? UartBase + AddrWidth'(8) :
                       (state == WRITE) ? UartBase + AddrWidth'(4) : '0;
        host_wdata_o = host_we_o ? DataWidth'(tx_byte) : '0;
        grant_o      = locked ? NumReq'(1) << owner : '0;
        req_ready_o  = host_we_o ? grant_o : '0;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for the line-locked UART arbiter with a
// one-cycle-latency status/TX device model and per-requester byte queues.
module tb_uart_tx_arbiter;
    localparam int N = 3;
    localparam logic [31:0] BASE = 32'h8000_1000;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N*8-1:0] req_data_i = '0;
    logic [N-1:0]   req_ready_o, grant_o;
    logic           busy_o, host_req_o, host_we_o;
    logic           host_rvalid_i = 1'b0;
    logic [31:0]    host_addr_o, host_wdata_o;
    logic [31:0]    host_rdata_i = '0;
    logic [3:0]     host_be_o;

    int checks = 0, errors = 0, cyc = 0, rd_cnt = 0, rdy_cnt = 0, full_until = 0;
    logic pend = 1'b0, pend_full = 1'b0;
    logic [7:0]   q [N][$];
    logic [31:0]  wr_wd [$], wr_addr [$], rd_addr [$];
    logic [3:0]   wr_be [$];
    logic [N-1:0] wr_rdy [$], wr_gnt [$];
    int           wr_cyc [$], rd_cyc [$];

    uart_tx_arbiter #(.NumReq(N), .UartBase(BASE), .MaxBurst(4), .LockTimeout(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .grant_o(grant_o), .busy_o(busy_o), .host_req_o(host_req_o),
        .host_addr_o(host_addr_o), .host_we_o(host_we_o), .host_be_o(host_be_o),
        .host_wdata_o(host_wdata_o), .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Device model, bus monitor and requester feeders, all mid-cycle.
    always @(negedge clk_i) begin
        cyc++;
        host_rvalid_i = pend;
        host_rdata_i = pend ? (pend_full ? 32'h0000_0002 : 32'hFFFF_FFFD) : 32'h0;
        pend = host_req_o;
        pend_full = 1'b0;
        if (host_req_o && !host_we_o) begin
            rd_cnt++;
            pend_full = rd_cnt <= full_until;
            rd_cyc.push_back(cyc);
            rd_addr.push_back(host_addr_o);
        end
        if (host_req_o && host_we_o) begin
            wr_wd.push_back(host_wdata_o);
            wr_addr.push_back(host_addr_o);
            wr_be.push_back(host_be_o);
            wr_rdy.push_back(req_ready_o);
            wr_gnt.push_back(grant_o);
            wr_cyc.push_back(cyc);
        end
        if (req_ready_o != '0) rdy_cnt++;
        for (int n = 0; n < N; n++)
            if (req_ready_o[n] && q[n].size() > 0) void'(q[n].pop_front());
        for (int n = 0; n < N; n++) begin
            req_valid_i[n] = q[n].size() > 0;
            req_data_i[8*n +: 8] = (q[n].size() > 0) ? q[n][0] : 8'h00;
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        full_until = 0;
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
    endtask

    task automatic wait_wr(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk_i);
            #2 ok = wr_wd.size() >= n;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #2;
        checks++; if (grant_o !== 3'b000 || req_ready_o !== 3'b000) begin errors++; $display("FAIL reset_grant_ready got %b/%b want 000/000", grant_o, req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if ({host_req_o, host_we_o, host_be_o} !== 6'b0) begin errors++; $display("FAIL reset_host_ctrl got %b want 0", {host_req_o, host_we_o, host_be_o}); end
        checks++; if ({host_addr_o, host_wdata_o} !== 64'h0) begin errors++; $display("FAIL reset_host_bus got %h want 0", {host_addr_o, host_wdata_o}); end
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #2;
        checks++; if (busy_o !== 1'b0 || rd_cyc.size() != 0) begin errors++; $display("FAIL idle_no_req got busy=%b reads=%0d want 0/0", busy_o, rd_cyc.size()); end
    endtask

    task automatic test_single_line();
        logic [7:0] ed [3] = '{8'h48, 8'h69, 8'h0A};
        int nb, c0;
        bit ok;
        do_reset();
        nb = wr_wd.size();
        c0 = rdy_cnt;
        for (int i = 0; i < 3; i++) q[0].push_back(ed[i]);
        wait_wr(nb + 3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d writes want 3", wr_wd.size() - nb); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wr_wd[nb+i] !== {24'h0, ed[i]}) begin errors++; $display("FAIL single_wdata[%0d] got %h want %h", i, wr_wd[nb+i], {24'h0, ed[i]}); end
            checks++; if (wr_addr[nb+i] !== BASE + 32'd4 || wr_be[nb+i] !== 4'b0001) begin errors++; $display("FAIL single_addr_be[%0d] got %h/%b want %h/0001", i, wr_addr[nb+i], wr_be[nb+i], BASE + 32'd4); end
            checks++; if (wr_rdy[nb+i] !== 3'b001 || wr_gnt[nb+i] !== 3'b001) begin errors++; $display("FAIL single_ready_grant[%0d] got %b/%b want 001/001", i, wr_rdy[nb+i], wr_gnt[nb+i]); end
        end
        for (int i = 1; i < 3; i++) begin
            checks++; if (wr_cyc[nb+i] - wr_cyc[nb+i-1] != 5) begin errors++; $display("FAIL single_spacing[%0d] got %0d want 5", i, wr_cyc[nb+i] - wr_cyc[nb+i-1]); end
        end
        checks++; if (rd_addr[rd_addr.size()-1] !== BASE + 32'd8) begin errors++; $display("FAIL poll_addr got %h want %h", rd_addr[rd_addr.size()-1], BASE + 32'd8); end
        repeat (3) @(posedge clk_i);
        #2;
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL single_release got %b want 000", grant_o); end
        checks++; if (rdy_cnt - c0 != 3 || wr_wd.size() != nb + 3) begin errors++; $display("FAIL single_counts got %0d/%0d want 3/3", rdy_cnt - c0, wr_wd.size() - nb); end
    endtask

    task automatic test_two_lines();
        logic [7:0]   ed [10] = '{8'h61, 8'h62, 8'h0A, 8'h61, 8'h62, 8'h0A, 8'h32, 8'h0A, 8'h30, 8'h0A};
        logic [N-1:0] em [10] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
        int nb;
        bit ok;
        do_reset();
        nb = wr_wd.size();
        for (int n = 0; n < 2; n++) begin
            q[n].push_back(8'h61); q[n].push_back(8'h62); q[n].push_back(8'h0A);
        end
        wait_wr(nb + 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_lines_timeout got %0d writes want 6", wr_wd.size() - nb); end
        q[0].push_back(8'h30); q[0].push_back(8'h0A);
        q[2].push_back(8'h32); q[2].push_back(8'h0A);
        wait_wr(nb + 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pointer_timeout got %0d writes want 10", wr_wd.size() - nb); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (wr_wd[nb+i] !== {24'h0, ed[i]} || wr_rdy[nb+i] !== em[i]) begin errors++; $display("FAIL two_lines[%0d] got %h/%b want %h/%b", i, wr_wd[nb+i], wr_rdy[nb+i], ed[i], em[i]); end
        end
    endtask

    task automatic test_full_status();
        int nb, rb, c0;
        bit ok;
        do_reset();
        nb = wr_wd.size();
        rb = rd_cyc.size();
        c0 = rdy_cnt;
        full_until = rd_cnt + 4;
        q[0].push_back(8'h51);
        wait_wr(nb + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout got %0d writes want 1", wr_wd.size() - nb); end
        checks++; if (rd_cyc.size() - rb != 5) begin errors++; $display("FAIL full_reads got %0d want 5", rd_cyc.size() - rb); end
        checks++; if (wr_cyc[nb] - rd_cyc[rb] != 10) begin errors++; $display("FAIL full_latency got %0d want 10", wr_cyc[nb] - rd_cyc[rb]); end
        checks++; if (wr_wd[nb] !== 32'h51 || wr_rdy[nb] !== 3'b001) begin errors++; $display("FAIL full_write got %h/%b want 00000051/001", wr_wd[nb], wr_rdy[nb]); end
        checks++; if (rdy_cnt - c0 != 1) begin errors++; $display("FAIL full_ready_count got %0d want 1", rdy_cnt - c0); end
    endtask

    task automatic test_max_burst();
        logic [7:0]   ed [9] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h70, 8'h71, 8'h0A, 8'h45, 8'h46};
        logic [N-1:0] em [9] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b100, 3'b100};
        int nb;
        bit ok;
        do_reset();
        nb = wr_wd.size();
        for (int i = 0; i < 6; i++) q[2].push_back(8'h41 + 8'(i));
        wait_wr(nb + 1, ok);
        q[0].push_back(8'h70); q[0].push_back(8'h71); q[0].push_back(8'h0A);
        wait_wr(nb + 9, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout got %0d writes want 9", wr_wd.size() - nb); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (wr_wd[nb+i] !== {24'h0, ed[i]} || wr_rdy[nb+i] !== em[i]) begin errors++; $display("FAIL burst[%0d] got %h/%b want %h/%b", i, wr_wd[nb+i], wr_rdy[nb+i], ed[i], em[i]); end
        end
    endtask

    task automatic test_timeout();
        int nb, w;
        bit ok;
        do_reset();
        nb = wr_wd.size();
        q[0].push_back(8'h78);
        wait_wr(nb + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_first got %0d writes want 1", wr_wd.size() - nb); end
        w = wr_cyc[nb];
        while (cyc < w + 5) begin @(posedge clk_i); #2; end
        q[1].push_back(8'h31);
        while (cyc < w + 16) begin @(posedge clk_i); #2; end
        checks++; if (grant_o !== 3'b001 || wr_wd.size() != nb + 1) begin errors++; $display("FAIL timeout_hold got %b/%0d want 001/1", grant_o, wr_wd.size() - nb); end
        @(posedge clk_i);
        #2;
        checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL timeout_release got %b want 000", grant_o); end
        wait_wr(nb + 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_second got %0d writes want 2", wr_wd.size() - nb); end
        checks++; if (wr_wd[nb+1] !== 32'h31 || wr_rdy[nb+1] !== 3'b010) begin errors++; $display("FAIL timeout_serve got %h/%b want 00000031/010", wr_wd[nb+1], wr_rdy[nb+1]); end
        checks++; if (wr_cyc[nb+1] - w != 21) begin errors++; $display("FAIL timeout_cycle got %0d want 21", wr_cyc[nb+1] - w); end
    endtask

    task automatic test_reset_mid();
        int nb, c0;
        bit ok, found;
        do_reset();
        nb = wr_wd.size();
        c0 = rdy_cnt;
        q[0].push_back(8'h52);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk_i);
            #2 found = host_req_o && !host_we_o;
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_poll got none want status read"); end
        @(posedge clk_i);
        #3;
        checks++; if (busy_o !== 1'b1 || grant_o !== 3'b001 || host_req_o !== 1'b0) begin errors++; $display("FAIL mid_wait_stat got %b/%b/%b want 1/001/0", busy_o, grant_o, host_req_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if ({busy_o, grant_o, req_ready_o} !== 7'b0) begin errors++; $display("FAIL mid_reset_ctrl got %b want 0", {busy_o, grant_o, req_ready_o}); end
        checks++; if ({host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o} !== 70'b0) begin errors++; $display("FAIL mid_reset_host got %h want 0", {host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o}); end
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        checks++; if (rdy_cnt != c0 || wr_wd.size() != nb) begin errors++; $display("FAIL mid_no_consume got %0d/%0d want 0/0", rdy_cnt - c0, wr_wd.size() - nb); end
        wait_wr(nb + 1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_resend_timeout got %0d writes want 1", wr_wd.size() - nb); end
        checks++; if (wr_wd[nb] !== 32'h52 || wr_rdy[nb] !== 3'b001) begin errors++; $display("FAIL mid_resend got %h/%b want 00000052/001", wr_wd[nb], wr_rdy[nb]); end
        repeat (10) @(posedge clk_i);
        #2;
        checks++; if (wr_wd.size() != nb + 1 || rdy_cnt - c0 != 1) begin errors++; $display("FAIL mid_once got %0d/%0d want 1/1", wr_wd.size() - nb, rdy_cnt - c0); end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_two_lines();
        test_full_status();
        test_max_burst();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NumReq byte-stream requesters (e.g. core printf path, debug/trace source, boot monitor).
- Acts as a bus host on the UART device port:
  - polls the status register until the TX FIFO is not full;
  - writes one byte to the TX register.
- Grants are line-locked, so bytes from different requesters never interleave inside a line.
- Lock release points: line-end byte, MaxBurst bytes sent, or owner idle for LockTimeout cycles. Priority then rotates round-robin.

Parameters:
- NumReq, 3, number of requesters (2..8).
- UartBase, 32'h8000_1000, UART base address on the device bus.
- AddrWidth, 32, host address width.
- DataWidth, 32, host data width.
- LineEnd, 8'h0A, byte that ends a line and releases the lock.
- MaxBurst, 64, maximum bytes per grant before forced release (>=1).
- LockTimeout, 1024, idle cycles with owner valid low before release (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  requester n has a byte pending
- req_data_i  in  NumReq*8  byte of requester n at [8n+7:8n]; stable while valid
- req_ready_o  out  NumReq  one-cycle pulse: byte of requester n consumed
- grant_o  out  NumReq  one-hot current lock owner, zero when unlocked
- busy_o  out  1  FSM not in IDLE
- host_req_o  out  1  bus request, single cycle per access
- host_addr_o  out  AddrWidth  UartBase+8 (status) or UartBase+4 (TX)
- host_we_o  out  1  1 for TX write, 0 for status read
- host_be_o  out  4  always 4'b0001 when host_req_o is 1, else 0
- host_wdata_o  out  DataWidth  {zeros, byte} on write, else 0
- host_rvalid_i  in  1  response, one cycle after every request (read and write)
- host_rdata_i  in  DataWidth  status read data; bit1 = TX FIFO full

Behaviour:
- Reset values:
  - FSM = IDLE; grant_o = 0; req_ready_o = 0; busy_o = 0.
  - All host_* outputs = 0.
  - Round-robin pointer = 0; burst counter = 0; timeout counter = 0.
- Reset asserted mid-transaction aborts the transaction immediately. The byte is not consumed (no ready pulse) and is re-sent after reset.
- Arbitration happens only in IDLE with no lock held:
  - select the first valid requester starting at the pointer, wrapping modulo NumReq;
  - set grant_o, clear the burst counter, go to POLL.
- With a lock held in IDLE:
  - owner valid high -> POLL;
  - other requesters are ignored.
- FSM states:
  - IDLE: as above. While locked and owner valid low, the timeout counter increments. On reaching LockTimeout-1: release the lock, pointer = owner+1 mod NumReq; the release takes effect that cycle, arbitration follows the next cycle.
  - POLL: host_req_o=1, we=0, addr=UartBase+8, for exactly one cycle -> WAIT_STAT.
  - WAIT_STAT: wait for host_rvalid_i.
    - host_rdata_i[1]=1 (full) -> POLL; repoll back-to-back, no limit.
    - Otherwise -> WRITE.
  - WRITE: for one cycle, host_req_o=1, we=1, addr=UartBase+4, wdata=owner byte; req_ready_o[owner] pulses in the same cycle -> WAIT_WR.
  - WAIT_WR: wait for host_rvalid_i; burst counter +1, saturating at MaxBurst.
    - If the sent byte == LineEnd or the new count == MaxBurst: release the lock, pointer = owner+1 mod NumReq.
    - Go to IDLE either way.
- Throughput: 5 cycles per byte minimum (POLL, WAIT_STAT, WRITE, WAIT_WR, IDLE), plus 2 cycles per full-status repoll.
- Owner drops valid mid-sequence: the lock is held. The byte is latched at POLL entry, so WRITE sends the latched byte and data changes after POLL are ignored.
- The timeout counter clears on any owner valid high and on lock change.
- host_rvalid_i in IDLE or POLL is ignored (no outstanding request).
- A single requester streaming forever with no LineEnd is released every MaxBurst bytes. It is regranted immediately only if no other requester is valid.

Test Plan:
- Single requester 0 sends "Hi\n" with the status model always not-full:
  - host writes 0x48, 0x69, 0x0A to UartBase+4, 5 cycles apart;
  - three ready pulses;
  - grant_o 001 -> 000 after 0x0A.
- Requesters 0 and 1 both valid from reset, each sending "ab\n":
  - all of 0's line, then all of 1's line;
  - no interleaving;
  - pointer ends at 2.
- Status returns full (bit1=1) for 4 polls, then not-full:
  - exactly 5 status reads, then 1 write;
  - no ready pulse before the write.
- MaxBurst=4, requester 2 sends 6 bytes with no LineEnd while requester 0 is valid:
  - 4 bytes from 2, then requester 0's bytes, then the remaining 2 bytes from 2.
- Owner sends "x" then drops valid; LockTimeout=16; requester 1 goes valid at the 5th idle cycle:
  - grant_o stays on the owner through 16 idle cycles, then requester 1 is served.
- Reset pulsed during WAIT_STAT:
  - all outputs go to 0 immediately;
  - no ready pulse;
  - after reset the same byte is written once.
